// File: rtl/common_pkg.sv
// Shared UART transmitter types and constants.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package common;

   typedef enum logic [2:0] {
      PARITY_NONE  = 3'd0,
      PARITY_EVEN  = 3'd1,
      PARITY_ODD   = 3'd2,
      PARITY_MARK  = 3'd3,
      PARITY_SPACE = 3'd4
   } parity_t;

   typedef enum logic {
      STOP_ONE = 1'b0,
      STOP_TWO = 1'b1
   } stop_bits_t;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_START      = 3'd1,
      ST_DATA       = 3'd2,
      ST_PARITY     = 3'd3,
      ST_STOP       = 3'd4,
      ST_BREAK      = 3'd5,
      ST_BREAK_MARK = 3'd6
   } uart_tx_state_t;

   localparam logic [3:0] UART_MIN_DATA_BITS = 4'd5;

endpackage

// File: rtl/uart_tx_frame_baud.sv
// Baud divider: tick_o is high for one cycle every divisor_i+1 cycles.
// Latency: first tick divisor_i+1 cycles after restart_i.
// Backpressure: none; free-running, restart_i reloads the count.
module uart_baud_tick #(
   parameter int DIV_W = 24
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [DIV_W-1:0] divisor_i,
   input  logic             restart_i,
   output logic             tick_o
);

   logic [DIV_W-1:0] cnt_q;

   // Count down from the load value; terminal count 0 reloads, so the
   // full-scale divisor never needs a wider counter.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (restart_i || (cnt_q == '0)) begin
         cnt_q <= divisor_i;
      end else begin
         cnt_q <= cnt_q - DIV_W'(1);
      end
   end

   // Tick must not depend on restart_i: restart is derived from tick in the
   // streaming handshake path.
   assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter, 5..DATA_W data bits, parity, 1/2 stop, break; optional CTS via UART_TX_CTS_EN.
// Latency: start bit on txd_o from the handshake edge; done_o one cycle after the last stop cycle.
// Backpressure: tx_ready_o only in IDLE or the final stop cycle, with break_i low and CTS clear.
module uart_tx_frame
   import common::*;
#(
   parameter int DATA_W = 8,
   parameter int DIV_W  = 24
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [DIV_W-1:0]  divisor_i,
   input  logic [3:0]        data_bits_i,
   input  parity_t           parity_i,
   input  stop_bits_t        stop_bits_i,
   input  logic              break_i,
   input  logic [DATA_W-1:0] tx_data_i,
   input  logic              tx_valid_i,
   output logic              tx_ready_o,
   output logic              txd_o,
   output logic              busy_o,
`ifdef UART_TX_CTS_EN
   input  logic              cts_ni,
`endif
   output logic              done_o
);

   localparam logic [3:0] MAX_BITS = 4'(DATA_W);

   uart_tx_state_t    state_q, state_n;
   logic              txd_q, txd_n;
   logic              done_q, done_n;
   logic [DATA_W-1:0] sh_q, sh_n;
   logic [3:0]        bit_idx_q, bit_idx_n;
   logic              stop_idx_q, stop_idx_n;
   logic              brk_min_q, brk_min_n;
   logic [DIV_W-1:0]  div_q;
   logic [3:0]        nbits_q;
   logic              par_en_q, par_bit_q, two_stop_q;

   logic [3:0]        nbits_c;
   logic [DATA_W-1:0] data_c;
   logic              par_x, par_en_c, par_bit_c;
   logic              cts_clear;
   logic              tick, restart, load_div, load_cfg, last_stop, hs;
   logic [DIV_W-1:0]  div_sel;

`ifdef UART_TX_CTS_EN
   logic [1:0] cts_sync_q;

   // Two-flop synchroniser; resets to "not clear" so nothing leaves before CTS is seen.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cts_sync_q <= 2'b11;
      end else begin
         cts_sync_q <= {cts_sync_q[0], cts_ni};
      end
   end

   assign cts_clear = ~cts_sync_q[1];
`else
   assign cts_clear = 1'b1;
`endif

   // Frame configuration as it would be latched this cycle: clamped bit
   // count, payload masked to that count, and the parity bit it implies.
   always_comb begin
      nbits_c = data_bits_i;
      if (data_bits_i < UART_MIN_DATA_BITS) begin
         nbits_c = UART_MIN_DATA_BITS;
      end else if (data_bits_i > MAX_BITS) begin
         nbits_c = MAX_BITS;
      end
      for (int i = 0; i < DATA_W; i++) begin
         data_c[i] = tx_data_i[i] & (4'(i) < nbits_c);
      end
      par_x     = ^data_c;
      par_en_c  = 1'b1;
      par_bit_c = 1'b0;
      case (parity_i)
         PARITY_EVEN:  par_bit_c = par_x;
         PARITY_ODD:   par_bit_c = ~par_x;
         PARITY_MARK:  par_bit_c = 1'b1;
         PARITY_SPACE: par_bit_c = 1'b0;
         default:      par_en_c  = 1'b0;
      endcase
   end

   // A new frame or break reloads the divider from the live divisor; the
   // break release reuses the one latched for the break.
   assign div_sel = load_div ? divisor_i : div_q;

   uart_baud_tick #(.DIV_W(DIV_W)) u_baud (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .divisor_i (div_sel),
      .restart_i (restart),
      .tick_o    (tick)
   );

   // Next-state, next line level and handshake.
   always_comb begin
      state_n    = state_q;
      txd_n      = txd_q;
      done_n     = 1'b0;
      sh_n       = sh_q;
      bit_idx_n  = bit_idx_q;
      stop_idx_n = stop_idx_q;
      brk_min_n  = brk_min_q;
      restart    = 1'b0;
      load_div   = 1'b0;
      load_cfg   = 1'b0;

      last_stop  = (state_q == ST_STOP) && tick && (stop_idx_q == two_stop_q);
      tx_ready_o = rst_ni && !break_i && cts_clear && ((state_q == ST_IDLE) || last_stop);
      hs         = tx_valid_i && tx_ready_o;

      case (state_q)
         ST_IDLE, ST_STOP: begin
            if (state_q == ST_STOP && tick && !last_stop) begin
               stop_idx_n = 1'b1;
            end
            if (state_q == ST_IDLE || last_stop) begin
               done_n = (state_q == ST_STOP);
               if (break_i) begin
                  state_n   = ST_BREAK;
                  txd_n     = 1'b0;
                  restart   = 1'b1;
                  load_div  = 1'b1;
                  brk_min_n = 1'b0;
               end else if (hs) begin
                  state_n   = ST_START;
                  txd_n     = 1'b0;
                  restart   = 1'b1;
                  load_div  = 1'b1;
                  load_cfg  = 1'b1;
                  sh_n      = data_c;
               end else begin
                  state_n   = ST_IDLE;
                  txd_n     = 1'b1;
               end
            end
         end
         ST_START: begin
            if (tick) begin
               state_n   = ST_DATA;
               txd_n     = sh_q[0];
               sh_n      = sh_q >> 1;
               bit_idx_n = '0;
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (bit_idx_q == (nbits_q - 4'd1)) begin
                  if (par_en_q) begin
                     state_n = ST_PARITY;
                     txd_n   = par_bit_q;
                  end else begin
                     state_n    = ST_STOP;
                     txd_n      = 1'b1;
                     stop_idx_n = 1'b0;
                  end
               end else begin
                  bit_idx_n = bit_idx_q + 4'd1;
                  txd_n     = sh_q[0];
                  sh_n      = sh_q >> 1;
               end
            end
         end
         ST_PARITY: begin
            if (tick) begin
               state_n    = ST_STOP;
               txd_n      = 1'b1;
               stop_idx_n = 1'b0;
            end
         end
         ST_BREAK: begin
            txd_n = 1'b0;
            if (tick) begin
               brk_min_n = 1'b1;
            end
            // Release only once a full bit time of space has gone out.
            if (!break_i && (brk_min_q || tick)) begin
               state_n = ST_BREAK_MARK;
               txd_n   = 1'b1;
               restart = 1'b1;
            end
         end
         ST_BREAK_MARK: begin
            txd_n = 1'b1;
            if (tick) begin
               state_n = ST_IDLE;
            end
         end
         default: begin
            state_n = ST_IDLE;
            txd_n   = 1'b1;
         end
      endcase
   end

   // State, line register and per-frame configuration latch.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         txd_q      <= 1'b1;
         done_q     <= 1'b0;
         sh_q       <= '0;
         bit_idx_q  <= '0;
         stop_idx_q <= 1'b0;
         brk_min_q  <= 1'b0;
         div_q      <= '0;
         nbits_q    <= UART_MIN_DATA_BITS;
         par_en_q   <= 1'b0;
         par_bit_q  <= 1'b0;
         two_stop_q <= 1'b0;
      end else begin
         state_q    <= state_n;
         txd_q      <= txd_n;
         done_q     <= done_n;
         sh_q       <= sh_n;
         bit_idx_q  <= bit_idx_n;
         stop_idx_q <= stop_idx_n;
         brk_min_q  <= brk_min_n;
         if (load_div) begin
            div_q <= divisor_i;
         end
         if (load_cfg) begin
            nbits_q    <= nbits_c;
            par_en_q   <= par_en_c;
            par_bit_q  <= par_bit_c;
            two_stop_q <= (stop_bits_i == STOP_TWO);
         end
      end
   end

   assign txd_o  = txd_q;
   assign done_o = done_q;
   assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: table of frames plus streaming, break and reset sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_frame;
   import common::*;

   logic        clk;
   logic        rst_ni;
   logic [23:0] divisor_i;
   logic [3:0]  data_bits_i;
   parity_t     parity_i;
   stop_bits_t  stop_bits_i;
   logic        break_i;
   logic [8:0]  tx_data_i;
   logic        tx_valid_i;
   logic        tx_ready_o;
   logic        txd_o;
   logic        busy_o;
   logic        done_o;
`ifdef UART_TX_CTS_EN
   logic        cts_ni;
`endif

   int checks = 0;
   int errors = 0;

   uart_tx_frame #(.DATA_W(9), .DIV_W(24)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .divisor_i   (divisor_i),
      .data_bits_i (data_bits_i),
      .parity_i    (parity_i),
      .stop_bits_i (stop_bits_i),
      .break_i     (break_i),
      .tx_data_i   (tx_data_i),
      .tx_valid_i  (tx_valid_i),
      .tx_ready_o  (tx_ready_o),
      .txd_o       (txd_o),
      .busy_o      (busy_o),
`ifdef UART_TX_CTS_EN
      .cts_ni      (cts_ni),
`endif
      .done_o      (done_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  bits;
      parity_t     par;
      stop_bits_t  stop;
      logic [23:0] div;
      logic [8:0]  data;
      logic [15:0] seq;   // expected line level per bit time, first bit at [0]
      int          n;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic bit_of(input logic [15:0] s, input int i);
      logic [15:0] t;
      t = s >> i;
      return t[0];
   endfunction

   task automatic set_cfg(input logic [3:0] b, input parity_t p, input stop_bits_t s, input logic [23:0] d);
      data_bits_i = b;
      parity_i    = p;
      stop_bits_i = s;
      divisor_i   = d;
   endtask

   // One frame, config scrambled right after the handshake.
   task automatic run_vec(input int idx, input vec_t v);
      int bt, tot;
      bt  = int'(v.div) + 1;
      tot = v.n * bt;
      @(negedge clk);
      set_cfg(v.bits, v.par, v.stop, v.div);
      tx_data_i  = v.data;
      tx_valid_i = 1'b1;
      #1 check($sformatf("v%0d_ready_idle", idx), tx_ready_o, 1);
      @(negedge clk);
      tx_valid_i = 1'b0;
      set_cfg(4'd5, PARITY_ODD, STOP_TWO, 24'd0);
      tx_data_i  = 9'h1FF;
      check($sformatf("v%0d_busy", idx), busy_o, 1);
      for (int c = 0; c < tot; c++) begin
         check($sformatf("v%0d_txd_c%0d", idx, c), txd_o, bit_of(v.seq, c / bt));
         check($sformatf("v%0d_done_c%0d", idx, c), done_o, 0);
         @(negedge clk);
      end
      check($sformatf("v%0d_done_end", idx), done_o, 1);
      check($sformatf("v%0d_txd_end", idx), txd_o, 1);
      check($sformatf("v%0d_busy_end", idx), busy_o, 0);
      @(negedge clk);
      check($sformatf("v%0d_done_once", idx), done_o, 0);
   endtask

   initial begin
      logic [7:0] bytes [3];
      logic [7:0] bv;
      logic       exp_b;
      int         sent, ndone, f, b;
      logic       prev_hs;

      vecs[0] = '{4'd8,  PARITY_NONE,  STOP_ONE, 24'd3, 9'h0A5, 16'h034A, 10};
      vecs[1] = '{4'd7,  PARITY_EVEN,  STOP_TWO, 24'd0, 9'h053, 16'h06A6, 11};
      vecs[2] = '{4'd5,  PARITY_ODD,   STOP_ONE, 24'd2, 9'h1FF, 16'h00BE, 8};
      vecs[3] = '{4'd5,  PARITY_EVEN,  STOP_ONE, 24'd1, 9'h0E0, 16'h0080, 8};
      vecs[4] = '{4'd3,  PARITY_MARK,  STOP_ONE, 24'd0, 9'h00A, 16'h00D4, 8};
      vecs[5] = '{4'd15, PARITY_SPACE, STOP_TWO, 24'd1, 9'h155, 16'h1AAA, 13};
      vecs[6] = '{4'd9,  PARITY_NONE,  STOP_ONE, 24'd0, 9'h100, 16'h0600, 11};

      rst_ni     = 1'b0;
      break_i    = 1'b0;
      tx_valid_i = 1'b1;
      tx_data_i  = 9'h0;
      set_cfg(4'd8, PARITY_NONE, STOP_ONE, 24'd3);
`ifdef UART_TX_CTS_EN
      cts_ni = 1'b1;
`endif
      repeat (3) @(negedge clk);
      check("rst_txd", txd_o, 1);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_ready", tx_ready_o, 0);
      rst_ni     = 1'b1;
      tx_valid_i = 1'b0;
`ifdef UART_TX_CTS_EN
      repeat (4) @(negedge clk);
      check("cts_blocked", tx_ready_o, 0);
      cts_ni = 1'b0;
      #1 check("cts_sync0", tx_ready_o, 0);
      @(negedge clk);
      check("cts_sync1", tx_ready_o, 0);
      @(negedge clk);
      check("cts_clear", tx_ready_o, 1);
`else
      repeat (2) @(negedge clk);
      check("idle_ready", tx_ready_o, 1);
`endif

      for (int i = 0; i < 7; i++) begin
         run_vec(i, vecs[i]);
      end

      // Back-to-back streaming, 8N1, divisor 1: 3 frames of 20 cycles.
      bytes[0] = 8'h01; bytes[1] = 8'h80; bytes[2] = 8'hC3;
      @(negedge clk);
      set_cfg(4'd8, PARITY_NONE, STOP_ONE, 24'd1);
      tx_data_i  = {1'b0, bytes[0]};
      tx_valid_i = 1'b1;
      sent  = 1;
      ndone = 0;
      #1 prev_hs = tx_ready_o && tx_valid_i;
      check("st_ready0", prev_hs, 1);
      for (int c = 0; c <= 61; c++) begin
         @(negedge clk);
         if (prev_hs) begin
            if (sent < 3) begin
               tx_data_i = {1'b0, bytes[sent]};
               sent++;
            end else begin
               tx_valid_i = 1'b0;
            end
         end
         if (c < 60) begin
            f  = c / 20;
            b  = (c % 20) / 2;
            bv = bytes[f];
            if (b == 0)      exp_b = 1'b0;
            else if (b == 9) exp_b = 1'b1;
            else             exp_b = bv[0] ? ((bv >> (b - 1)) & 8'h1) != 0 : ((bv >> (b - 1)) & 8'h1) != 0;
         end else begin
            exp_b = 1'b1;
         end
         check($sformatf("st_txd_c%0d", c), txd_o, exp_b);
         check($sformatf("st_done_c%0d", c), done_o, (c == 20 || c == 40 || c == 60));
         if (done_o === 1'b1) ndone++;
         #1 prev_hs = tx_ready_o && tx_valid_i;
      end
      check("st_ndone", ndone, 3);
      check("st_sent", sent, 3);
      check("st_busy_end", busy_o, 0);

      // Break raised mid-frame for 50 cycles, divisor 3.
      @(negedge clk);
      set_cfg(4'd8, PARITY_NONE, STOP_ONE, 24'd3);
      tx_data_i  = 9'h000;
      tx_valid_i = 1'b1;
      @(negedge clk);
      tx_valid_i = 1'b0;
      for (int c = 0; c <= 70; c++) begin
         if (c == 10) break_i = 1'b1;
         if (c == 60) break_i = 1'b0;
         #1;
         check($sformatf("brk_txd_c%0d", c), txd_o, (c < 36) ? 0 : (c < 40) ? 1 : (c <= 60) ? 0 : 1);
         check($sformatf("brk_done_c%0d", c), done_o, (c == 40));
         check($sformatf("brk_busy_c%0d", c), busy_o, (c < 65));
         if (c == 50) check("brk_ready", tx_ready_o, 0);
         @(negedge clk);
      end

      // One-cycle break request from IDLE still gives one full bit time of space.
      break_i = 1'b1;
      #1 check("brk1_ready", tx_ready_o, 0);
      @(negedge clk);
      break_i = 1'b0;
      for (int c = 0; c <= 8; c++) begin
         check($sformatf("brk1_txd_c%0d", c), txd_o, (c < 4) ? 0 : 1);
         check($sformatf("brk1_busy_c%0d", c), busy_o, (c < 8));
         @(negedge clk);
      end

      // Reset asserted during data bit 3.
      set_cfg(4'd8, PARITY_NONE, STOP_ONE, 24'd3);
      tx_data_i  = 9'h000;
      tx_valid_i = 1'b1;
      @(negedge clk);
      tx_valid_i = 1'b0;
      repeat (17) @(negedge clk);
      check("mrst_txd_before", txd_o, 0);
      check("mrst_busy_before", busy_o, 1);
      rst_ni = 1'b0;
      #1 check("mrst_ready", tx_ready_o, 0);
      @(negedge clk);
      check("mrst_txd", txd_o, 1);
      check("mrst_busy", busy_o, 0);
      check("mrst_done", done_o, 0);
      rst_ni = 1'b1;
      repeat (3) @(negedge clk);
      check("mrst_ready_after", tx_ready_o, 1);
      run_vec(99, vecs[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter with a valid/ready byte interface, used in place of the fixed 7/8-bit transmitter wherever a peripheral needs wider baud dividers, 5..DATA_W data bits, 1/2 stop bits, break generation or gap-free streaming. It sits between a TX FIFO (upstream, valid/ready) and the `txd` pad. Per-frame configuration is latched at frame start, so software may reprogram it at any time without corrupting a frame in flight.

## Interface
Parameters:
- `DATA_W`, 8: maximum data bits per frame; legal range 5..9.
- `DIV_W`, 24: width of the baud divisor.

Ports:
- `clk_i` in 1: sole clock.
- `rst_ni` in 1: reset; synchronous, active-low.
- `divisor_i` in DIV_W: cycles per bit minus one; 0 gives 1 cycle per bit.
- `data_bits_i` in 4: data bits per frame; values <5 are treated as 5, values >DATA_W as DATA_W.
- `parity_i` in `parity_t`: NONE/EVEN/ODD/MARK/SPACE.
- `stop_bits_i` in `stop_bits_t`: STOP_ONE / STOP_TWO.
- `break_i` in 1: request break (line held low).
- `tx_data_i` in DATA_W: frame payload, LSB first.
- `tx_valid_i` in 1: payload valid.
- `tx_ready_o` out 1: payload accepted when `tx_valid_i && tx_ready_o`.
- `txd_o` out 1: serial line, idle high; registered.
- `busy_o` out 1: a frame or break is in progress.
- `done_o` out 1: one-cycle pulse at the end of each frame's last stop bit.
- `cts_ni` in 1: clear-to-send, active-low; present only with `UART_TX_CTS_EN`.

## Operation
- States: IDLE, START, DATA, PARITY, STOP, BREAK, BREAK_MARK.
- Bit time: `divisor_i+1` cycles, from the divisor latched at frame start.
- On handshake:
  - latch data, divisor, bit count, parity mode and stop count;
  - move to START.
- DATA: sends N bits LSB first.
- PARITY: skipped when mode is NONE. Otherwise:
  - EVEN = XOR of the N data bits;
  - ODD = its inverse;
  - MARK = 1; SPACE = 0.
- STOP: 1 or 2 bit times of mark. Then IDLE, or START directly for a back-to-back frame.
- `tx_ready_o` is high when all of the following hold:
  - `rst_ni` is high;
  - `break_i` is low;
  - CTS is clear;
  - state is IDLE, or the cycle is the final cycle of the final stop bit (zero-gap streaming).
- `break_i` high in IDLE: enter BREAK; `txd_o`=0 while `break_i` is high (minimum one bit time). On release: BREAK_MARK (one bit time of mark), then IDLE.
- `break_i` raised mid-frame: the frame completes unchanged, then BREAK is entered.
- `busy_o` = state is not IDLE.
- `tx_data_i` bits at or above the latched data bit count are ignored.

## Timing
- Reset values: `txd_o`=1, `busy_o`=0, `done_o`=0, `tx_ready_o`=0 while `rst_ni`=0; state IDLE; divider cleared.
- Reset asserted mid-frame aborts the frame; `txd_o` returns to 1 on the next edge.
- Handshake on edge k: `txd_o`=0 (start bit) from edge k; each subsequent bit changes every `divisor+1` edges.
- Frame length is `(1+N+P+S)*(divisor+1)` cycles, where P is 0/1 and S is 1/2.
- `done_o` is high in the cycle following the last stop-bit cycle. With streaming, the next start bit begins in that same cycle (no idle gap).
- Divider counts down from the latched divisor. Terminal count 0 advances the bit, with no wrap ambiguity at divisor = 2^DIV_W-1.
- Changes to config inputs mid-frame take effect at the next frame.

## Configuration
- `UART_TX_CTS_EN` defined:
  - `cts_ni` port exists and passes through a 2-flop synchroniser;
  - `tx_ready_o` is additionally gated by synchronised `cts_ni`=0;
  - a frame in flight always completes.
- Undefined: no `cts_ni` port; CTS is always clear.

## Structure
- Package `common`:
  - `parity_t`;
  - new `stop_bits_t`;
  - `uart_tx_state_t` enum;
  - constant `UART_MIN_DATA_BITS`=5.
- Sub-module `uart_baud_tick`, parametrised by DIV_W:
  - inputs: divisor and `restart_i`;
  - output: one-cycle `tick_o` every `divisor+1` cycles;
  - `restart_i` reloads the count.

## Test plan
- 8N1, divisor=3, send 0xA5:
  - `txd_o` = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles;
  - `done_o` pulses once, 40 cycles after the handshake.
- 7E2, divisor=0, send 0x53 (bits 1100101, four ones): `txd_o` = 0,1,1,0,0,1,0,1,0,1,1.
- 5O1, DATA_W=9, send 0x1FF: frame is start, 1,1,1,1,1, then parity 0, then stop.
- `tx_valid_i` held high, 3 bytes, 8N1, divisor=1:
  - no idle cycle between frames;
  - total 60 cycles; 3 `done_o` pulses.
- `break_i` raised mid-frame for 50 cycles, divisor=3:
  - the frame completes;
  - `txd_o` is low for at least 4 cycles until release, then high for 4 cycles;
  - `busy_o` falls afterwards.
- `rst_ni` low at bit 3 of a frame → next cycle `txd_o`=1, `busy_o`=0. With `UART_TX_CTS_EN` and `cts_ni`=1, `tx_ready_o` stays 0 until 2 cycles after `cts_ni` falls.
